// File: rtl/byte_unstriping_pkg.sv
// Shared defaults and width helper for the N-lane byte unstriper.
package byte_unstriping_pkg;

    localparam int DEF_NUM_LANES = 2;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_DEPTH     = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_unstriping_n_lane_fifo.sv
// Per-lane word FIFO; a push into a full FIFO is accepted only when a pop frees a slot at the same edge.
module lane_fifo
    import byte_unstriping_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && (!full_q || do_pop);
    assign ovf     = push && !do_push;
    assign full    = full_q;
    assign empty   = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/byte_unstriping_n.sv
// Merges NUM_LANES buffered lanes into one stream in strict round-robin order with output backpressure.
module byte_unstriping_n
    import byte_unstriping_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_LANES*WIDTH-1:0] lane_data,
    input  logic [NUM_LANES-1:0]       lane_valid,
    output logic [NUM_LANES-1:0]       lane_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [NUM_LANES-1:0]       overflow
);

    localparam int            PW   = clog2(NUM_LANES);
    localparam logic [PW-1:0] LAST = PW'(NUM_LANES - 1);

    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic [NUM_LANES-1:0] overflow_q;
    logic [NUM_LANES-1:0] pop, full, empty, ovf;
    logic [WIDTH-1:0]     dout [NUM_LANES];
    logic                 loadable, take;

    // An empty current lane stalls everything so lane order is never broken.
    assign loadable = !valid_q || ready_in;
    assign take     = loadable && !empty[rr_ptr_q];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign pop[g] = take && (rr_ptr_q == PW'(g));

        lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (lane_valid[g]),
            .pop   (pop[g]),
            .din   (lane_data[g*WIDTH +: WIDTH]),
            .full  (full[g]),
            .empty (empty[g]),
            .dout  (dout[g]),
            .ovf   (ovf[g])
        );
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        if (loadable) begin
            valid_d = take;
            if (take) begin
                data_d   = dout[rr_ptr_q];
                rr_ptr_d = (rr_ptr_q == LAST) ? '0 : rr_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_q | ovf;
        end
    end

    assign lane_ready = ~full;
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_byte_unstriping_n.sv
// Scoreboard bench: expected words are queued at stimulus time and checked by a monitor on each output handshake.
module tb_byte_unstriping_n;

    logic        clk;
    logic        reset;

    logic [63:0] lane_data_a;
    logic [1:0]  lane_valid_a;
    logic [1:0]  lane_ready_a;
    logic [31:0] data_out_a;
    logic        valid_out_a;
    logic        ready_a;
    logic [1:0]  overflow_a;

    logic [95:0] lane_data_b;
    logic [2:0]  lane_valid_b;
    logic [2:0]  lane_ready_b;
    logic [31:0] data_out_b;
    logic        valid_out_b;
    logic        ready_b;
    logic [2:0]  overflow_b;

    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    int          tests;
    int          fails;
    bit          done;

    byte_unstriping_n #(.NUM_LANES(2), .WIDTH(32), .DEPTH(4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .lane_data  (lane_data_a),
        .lane_valid (lane_valid_a),
        .lane_ready (lane_ready_a),
        .data_out   (data_out_a),
        .valid_out  (valid_out_a),
        .ready_in   (ready_a),
        .overflow   (overflow_a)
    );

    byte_unstriping_n #(.NUM_LANES(3), .WIDTH(32), .DEPTH(4)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .lane_data  (lane_data_b),
        .lane_valid (lane_valid_b),
        .lane_ready (lane_ready_b),
        .data_out   (data_out_b),
        .valid_out  (valid_out_b),
        .ready_in   (ready_b),
        .overflow   (overflow_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_step();
        logic [31:0] e;
        @(negedge clk);
        if (valid_out_a && ready_a) begin
            if (exp_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_a: got %h expected no word", data_out_a);
            end else begin
                e = exp_a.pop_front();
                chk("out_a", {32'h0, data_out_a}, {32'h0, e});
            end
        end
        if (valid_out_b && ready_b) begin
            if (exp_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_b: got %h expected no word", data_out_b);
            end else begin
                e = exp_b.pop_front();
                chk("out_b", {32'h0, data_out_b}, {32'h0, e});
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        done  = 1'b0;
        reset = 1'b1;
        lane_data_a  = {32'hB0, 32'hA0};
        lane_valid_a = 2'b11;
        ready_a      = 1'b1;
        lane_data_b  = '0;
        lane_valid_b = '0;
        ready_b      = 1'b1;

        fork
            begin
                repeat (3) tick();
                chk("rst_valid", {63'h0, valid_out_a}, 64'h0);
                chk("rst_data", {32'h0, data_out_a}, 64'h0);
                chk("rst_lane_ready", {62'h0, lane_ready_a}, 64'h3);
                chk("rst_overflow", {62'h0, overflow_a}, 64'h0);
                lane_valid_a = 2'b00;
                reset = 1'b0;
                tick();

                // basic interleave and first-word latency
                lane_data_a = {32'hB0, 32'hA0};
                lane_valid_a = 2'b11;
                exp_a.push_back(32'hA0); exp_a.push_back(32'hB0);
                tick();
                chk("lat_edge_k", {63'h0, valid_out_a}, 64'h0);
                lane_data_a = {32'hB1, 32'hA1};
                exp_a.push_back(32'hA1); exp_a.push_back(32'hB1);
                tick();
                chk("lat_edge_k1", {63'h0, valid_out_a}, 64'h1);
                lane_valid_a = 2'b00;
                repeat (5) tick();
                chk("basic_drained", 64'(exp_a.size()), 64'h0);

                // lane 1 data alone must not be emitted ahead of lane 0
                lane_data_a = {32'hB0, 32'h0};
                lane_valid_a = 2'b10;
                tick();
                lane_valid_a = 2'b00;
                repeat (3) tick();
                chk("stall_hold", {63'h0, valid_out_a}, 64'h0);
                lane_data_a = {32'h0, 32'hA0};
                lane_valid_a = 2'b01;
                exp_a.push_back(32'hA0); exp_a.push_back(32'hB0);
                tick();
                lane_valid_a = 2'b00;
                repeat (4) tick();
                chk("stall_drained", 64'(exp_a.size()), 64'h0);

                // backpressure: fill both lanes, overflow lane 0
                ready_a = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    lane_data_a  = {32'h200 + 32'(i), 32'h100 + 32'(i)};
                    lane_valid_a = (i < 4) ? 2'b11 : 2'b01;
                    tick();
                end
                chk("bp_lane_ready", {62'h0, lane_ready_a}, 64'h0);
                chk("bp_valid", {63'h0, valid_out_a}, 64'h1);
                chk("bp_data_first", {32'h0, data_out_a}, 64'h100);
                lane_data_a  = {32'h0, 32'h105};
                lane_valid_a = 2'b01;
                tick();
                lane_valid_a = 2'b00;
                chk("bp_overflow", {62'h0, overflow_a}, 64'h1);
                chk("bp_data_hold", {32'h0, data_out_a}, 64'h100);
                for (int i = 0; i < 4; i++) begin
                    exp_a.push_back(32'h100 + 32'(i));
                    exp_a.push_back(32'h200 + 32'(i));
                end
                exp_a.push_back(32'h104);
                ready_a = 1'b1;
                repeat (12) tick();
                chk("bp_drained", 64'(exp_a.size()), 64'h0);
                chk("bp_ready_back", {62'h0, lane_ready_a}, 64'h3);
                chk("bp_overflow_sticky", {62'h0, overflow_a}, 64'h1);
                // rr_ptr now sits on lane 1
                lane_data_a  = {32'h2FF, 32'h0};
                lane_valid_a = 2'b10;
                exp_a.push_back(32'h2FF);
                tick();
                lane_valid_a = 2'b00;
                repeat (3) tick();
                chk("realign_drained", 64'(exp_a.size()), 64'h0);

                // reset while words are buffered and valid_out is held
                ready_a = 1'b0;
                lane_data_a  = {32'hE1, 32'hD0};
                lane_valid_a = 2'b11;
                tick();
                lane_data_a  = {32'h0, 32'hD1};
                lane_valid_a = 2'b01;
                tick();
                lane_valid_a = 2'b00;
                chk("pre_reset_valid", {63'h0, valid_out_a}, 64'h1);
                #2 reset = 1'b1;
                #1;
                chk("mid_rst_valid", {63'h0, valid_out_a}, 64'h0);
                chk("mid_rst_data", {32'h0, data_out_a}, 64'h0);
                chk("mid_rst_lane_ready", {62'h0, lane_ready_a}, 64'h3);
                chk("mid_rst_overflow", {62'h0, overflow_a}, 64'h0);
                @(posedge clk);
                #1 reset = 1'b0;
                ready_a = 1'b1;
                repeat (4) tick();
                chk("post_rst_idle", {63'h0, valid_out_a}, 64'h0);
                lane_data_a  = {32'h5B, 32'h5A};
                lane_valid_a = 2'b11;
                exp_a.push_back(32'h5A); exp_a.push_back(32'h5B);
                tick();
                lane_valid_a = 2'b00;
                repeat (4) tick();
                chk("post_rst_drained", 64'(exp_a.size()), 64'h0);

                // three-lane wrap
                lane_data_b  = {32'h12, 32'h11, 32'h10};
                lane_valid_b = 3'b111;
                exp_b.push_back(32'h10); exp_b.push_back(32'h11); exp_b.push_back(32'h12);
                tick();
                lane_data_b  = {32'h15, 32'h14, 32'h13};
                exp_b.push_back(32'h13); exp_b.push_back(32'h14); exp_b.push_back(32'h15);
                tick();
                lane_valid_b = 3'b000;
                repeat (8) tick();
                chk("wrap_drained", 64'(exp_b.size()), 64'h0);
                lane_data_b  = {32'h0, 32'h0, 32'h16};
                lane_valid_b = 3'b001;
                exp_b.push_back(32'h16);
                tick();
                lane_valid_b = 3'b000;
                repeat (3) tick();
                chk("wrap_back_to_lane0", 64'(exp_b.size()), 64'h0);

                done = 1'b1;
            end
            begin
                while (!done) mon_step();
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_unstriping_n.md
# byte_unstriping_n

Parametrised N-lane byte unstriper: collects words arriving on NUM_LANES independent lanes and merges them into one output stream in strict round-robin order (lane 0, 1, …, NUM_LANES-1, 0, …).
- Generalises the fixed two-lane, two-clock unstriper to any lane count, data width and per-lane buffer depth.
- Runs on a single clock.
- Adds per-lane buffering, output backpressure and overflow reporting.
- Sits between the per-lane receive logic and the downstream single-stream consumer.

## Interface
Parameters:
- NUM_LANES, 2, number of input lanes (≥2, need not be a power of two)
- WIDTH, 32, data word width in bits
- DEPTH, 4, words of buffering per lane (≥2, power of two)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- lane_data  in  NUM_LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
- lane_valid  in  NUM_LANES  lane i word present this cycle
- lane_ready  out  NUM_LANES  lane i buffer not full (registered)
- data_out  out  WIDTH  merged output word
- valid_out  out  1  data_out holds a valid word
- ready_in  in  1  downstream accepts data_out this cycle
- overflow  out  NUM_LANES  sticky, lane i dropped a word

## Operation
- Each lane feeds its own DEPTH-entry FIFO.
  - A push occurs when lane_valid[i]=1.
  - The push is accepted if the FIFO is not full, or if it is full and is popped at the same edge.
  - Otherwise the word is dropped and overflow[i] is set.
  - overflow is cleared only by reset.
- rr_ptr (0..NUM_LANES-1) selects the lane to emit next.
  - It wraps from NUM_LANES-1 to 0.
  - It advances by one only when a word is popped from lane rr_ptr.
  - It never skips a lane. An empty current lane stalls the output even if other lanes hold data, so order is preserved.
- Output register is loadable when valid_out=0 or ready_in=1.
  - Loadable and FIFO[rr_ptr] non-empty: pop, load data_out, set valid_out=1, advance rr_ptr.
  - Loadable and FIFO[rr_ptr] empty: valid_out←0; data_out holds its last value.
  - Not loadable (valid_out=1, ready_in=0): data_out, valid_out and rr_ptr hold. No pops occur.
- Push and pop on the same FIFO in the same edge: count unchanged, both take effect.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

## Timing
- Reset values (asynchronous, immediate):
  - valid_out=0, data_out=0
  - rr_ptr=0
  - all FIFOs empty
  - lane_ready=all ones, overflow=0
- Latency:
  - Word pushed at edge k into an empty FIFO that is lane rr_ptr, with the output loadable: valid_out=1 after edge k+1.
  - No combinational path from lane_data to data_out.
- Throughput: one word per cycle sustained when all lanes keep their FIFOs non-empty and ready_in=1.
- lane_ready deasserts the cycle after count reaches DEPTH. It reasserts the cycle after a pop brings count below DEPTH.
- Reset asserted mid-stream:
  - All buffered words are discarded and rr_ptr returns to 0.
  - First word after reset release comes from lane 0.
- valid_out/data_out hold stable while valid_out=1 and ready_in=0 (AXI-style: no retraction).

## Structure
- Package byte_unstriping_pkg holds:
  - default constants for NUM_LANES, WIDTH, DEPTH
  - a function clog2 for pointer widths
- Sub-module lane_fifo (WIDTH, DEPTH) is instantiated NUM_LANES times in a generate loop. It provides:
  - push, pop, full, empty, dout
  - an overflow pulse for the sticky bits
- Top level contains rr_ptr, the output register and the lane-select mux.

## Test plan
Defaults: NUM_LANES=2, WIDTH=32, DEPTH=4 unless noted.
- Reset check: hold reset, drive lane_valid=2'b11 → valid_out=0, lane_ready=2'b11, overflow=0. Release reset → first output is from lane 0.
- Basic interleave: lane0 pushes 0xA0,0xA1, lane1 pushes 0xB0,0xB1 simultaneously, ready_in=1 → data_out sequence A0,B0,A1,B1, valid_out first high 2 edges after first push.
- Stall ordering: push 0xB0 on lane1 only → valid_out stays 0. Then push 0xA0 on lane0 → output is A0 then B0.
- Backpressure: ready_in=0 with both FIFOs filled to 4 → lane_ready=2'b00, data_out holds first word. A fifth push on lane0 → overflow[0]=1, word lost. Release ready_in → remaining 8 words drain in round-robin order.
- Wrap with NUM_LANES=3: push 0x10..0x15 evenly across lanes → output 0x10,0x11,0x12,0x13,0x14,0x15 (lane order 0,1,2,0,1,2), rr_ptr back to 0.
- Reset mid-stream: assert reset while 3 words are buffered and valid_out=1 → all outputs return to reset values the same cycle. No stale word appears after release.
